key_step_debounce: RTL and testbench

//   Front end for the BCD 00-99 counter. Cleans a bouncing DE2 pushbutton
//   (KEY[3], active-low) into single-cycle step pulses on CLOCK_50.
//   The counter advances on step instead of being clocked directly by the raw key.
//   An optional auto-repeat mode emits extra steps while the key is held.

---
 rtl/key_step_debounce_if.sv | 21 ++
 rtl/key_step_debounce.sv | 145 ++++++++++++++
 tb/tb_key_step_debounce.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_step_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : key_step_debounce_if
// Purpose  : Board-side signal bundle for the key step debouncer.
//   KEY  [3:0]  KEY[0] async active-low reset, KEY[3] raw button (0 = pressed)
//   SW   [17:0] SW[1] auto-repeat enable
//   step        one-cycle step pulse to the BCD counter
//   LEDG        debounced pressed level
// Revision : 1.0 - initial release
// ============================================================================
interface key_step_debounce_if;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic        step;
  logic        LEDG;

  // master: board / stimulus side, slave: the debouncer
  modport master (output KEY, SW, input step, LEDG);
  modport slave  (input KEY, SW, output step, LEDG);
endinterface
`default_nettype wire

// File: rtl/key_step_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_step_debounce
// Purpose  : Turns a bouncing active-low pushbutton into single-cycle step
//            pulses, with optional auto-repeat while the key is held.
// Ports    :
//   CLOCK_50     in  system clock, rising edge
//   bus.KEY[0]   in  asynchronous active-low reset
//   bus.KEY[3]   in  raw button, 0 = pressed
//   bus.SW[1]    in  auto-repeat enable
//   bus.step     out registered one-cycle step pulse
//   bus.LEDG     out debounced pressed level
// Revision : 1.0 - initial release
// ============================================================================
module key_step_debounce #(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic          CLOCK_50,
  key_step_debounce_if.slave bus
);

  // All cycle parameters are expected to be >= 2 so that consecutive steps
  // are always separated by at least one idle cycle.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_HELD     = 3'd2,
    S_REPEAT   = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  logic             rst_n;
  logic             sw_rep;
  logic             sync1_q;
  logic             key_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             step_q,  step_d;
  logic             unused_bits;

  assign rst_n  = bus.KEY[0];
  assign sw_rep = bus.SW[1];

  // Remaining board inputs are intentionally ignored.
  assign unused_bits = ^{bus.KEY[2:1], bus.SW[17:2], bus.SW[0]};

  // Two-flop synchroniser; the key is inverted so key_s_q = 1 means pressed.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= ~bus.KEY[3];
      key_s_q <= sync1_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
    end
  end

  // Key-level tests are checked before timer terminal counts so that a
  // release or bounce always wins and never emits a step on the way out.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (key_s_q) state_d = S_PRESS_DB;
      end
      S_PRESS_DB: begin
        if (!key_s_q) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = S_HELD;
          timer_d = '0;
          step_d  = 1'b1;
        end
      end
      S_HELD: begin
        if (!key_s_q) begin
          state_d = S_REL_DB;
          timer_d = '0;
        end else if (!sw_rep) begin
          // Hold delay only runs while auto-repeat is enabled.
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d = S_REPEAT;
          timer_d = '0;
          step_d  = 1'b1;
        end
      end
      S_REPEAT: begin
        if (!key_s_q) begin
          state_d = S_REL_DB;
          timer_d = '0;
        end else if (!sw_rep) begin
          state_d = S_HELD;
          timer_d = '0;
        end else if (timer_q == REP_LAST) begin
          timer_d = '0;
          step_d  = 1'b1;
        end
      end
      S_REL_DB: begin
        if (key_s_q) begin
          // Release bounce: back to held, without a new step.
          state_d = S_HELD;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign bus.step = step_q;
  assign bus.LEDG = (state_q == S_HELD) || (state_q == S_REPEAT) ||
                    (state_q == S_REL_DB);

endmodule
`default_nettype wire

// File: tb/tb_key_step_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_step_debounce
// Purpose  : Directed self-checking bench for key_step_debounce with
//            DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
//            Bit i of a recorded vector is the output value just after
//            clock edge i of a pattern; bit i of a key mask means KEY[3]
//            is low when edge i samples it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_step_debounce;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  key_step_debounce_if bus ();

  key_step_debounce #(
    .DB_CYCLES     (4),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (3),
    .CNT_W         (4)
  ) dut (
    .CLOCK_50 (clk),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic run_pattern(input int n, input logic [63:0] klow,
                             input logic [63:0] swm,
                             output logic [63:0] st, output logic [63:0] ld);
    st = '0;
    ld = '0;
    for (int i = 1; i <= n; i++) begin
      bus.KEY[3] = ~klow[i];
      bus.SW[1]  = swm[i];
      @(posedge clk);
      #1;
      st[i] = bus.step;
      ld[i] = bus.LEDG;
    end
    bus.KEY[3] = 1'b1;
  endtask

  task automatic idle_gap();
    bus.KEY[3] = 1'b1;
    bus.SW[1]  = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.KEY = 4'b1110;
    bus.SW  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.step !== 1'b0) begin
      errors++;
      $display("FAIL reset_step: got %b expected 0", bus.step);
    end
    checks++;
    if (bus.LEDG !== 1'b0) begin
      errors++;
      $display("FAIL reset_ledg: got %b expected 0", bus.LEDG);
    end
    bus.KEY[0] = 1'b1;
    idle_gap();
  endtask

  task automatic test_reset_in_repeat();
    logic [63:0] st, ld;
    run_pattern(17, rng(1, 17), rng(1, 17), st, ld);
    checks++;
    if (st[17] !== 1'b1) begin
      errors++;
      $display("FAIL rr_step_before: got %b expected 1", st[17]);
    end
    #2;
    bus.KEY[0] = 1'b0;
    bus.KEY[3] = 1'b1;
    #1;
    checks++;
    if (bus.step !== 1'b0) begin
      errors++;
      $display("FAIL rr_step_async: got %b expected 0", bus.step);
    end
    checks++;
    if (bus.LEDG !== 1'b0) begin
      errors++;
      $display("FAIL rr_ledg_async: got %b expected 0", bus.LEDG);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.KEY[0] = 1'b1;
    run_pattern(20, '0, '0, st, ld);
    checks++;
    if (st !== 64'd0) begin
      errors++;
      $display("FAIL rr_after_steps: got %h expected %h", st, 64'd0);
    end
    checks++;
    if (ld !== 64'd0) begin
      errors++;
      $display("FAIL rr_after_ledg: got %h expected %h", ld, 64'd0);
    end
    idle_gap();
  endtask

  task automatic test_single_press();
    logic [63:0] st, ld, est, eld;
    run_pattern(45, rng(1, 30), '0, st, ld);
    est = '0;
    est[7] = 1'b1;
    eld = rng(7, 36);
    checks++;
    if (st !== est) begin
      errors++;
      $display("FAIL single_steps: got %h expected %h", st, est);
    end
    checks++;
    if (ld !== eld) begin
      errors++;
      $display("FAIL single_ledg: got %h expected %h", ld, eld);
    end
    idle_gap();
  endtask

  task automatic test_bounce();
    logic [63:0] st, ld, km;
    km = '0;
    for (int i = 1; i <= 40; i++) km[i] = ((i % 4) != 0);
    run_pattern(44, km, '0, st, ld);
    checks++;
    if (st !== 64'd0) begin
      errors++;
      $display("FAIL bounce_steps: got %h expected %h", st, 64'd0);
    end
    checks++;
    if (ld !== 64'd0) begin
      errors++;
      $display("FAIL bounce_ledg: got %h expected %h", ld, 64'd0);
    end
    idle_gap();
  endtask

  task automatic test_auto_repeat();
    logic [63:0] st, ld, est, eld;
    run_pattern(55, rng(1, 40), rng(1, 55), st, ld);
    est = '0;
    est[7]  = 1'b1; est[17] = 1'b1; est[20] = 1'b1; est[23] = 1'b1;
    est[26] = 1'b1; est[29] = 1'b1; est[32] = 1'b1; est[35] = 1'b1;
    est[38] = 1'b1; est[41] = 1'b1;
    eld = rng(7, 46);
    checks++;
    if (st !== est) begin
      errors++;
      $display("FAIL repeat_steps: got %h expected %h", st, est);
    end
    checks++;
    if (ld !== eld) begin
      errors++;
      $display("FAIL repeat_ledg: got %h expected %h", ld, eld);
    end
    idle_gap();
  endtask

  task automatic test_release_glitch();
    logic [63:0] st, ld, est, eld, km;
    km = rng(1, 20);
    km[23] = 1'b1;
    run_pattern(40, km, rng(1, 40), st, ld);
    est = '0;
    est[7] = 1'b1; est[17] = 1'b1; est[20] = 1'b1;
    eld = rng(7, 29);
    checks++;
    if (st !== est) begin
      errors++;
      $display("FAIL glitch_steps: got %h expected %h", st, est);
    end
    checks++;
    if (ld !== eld) begin
      errors++;
      $display("FAIL glitch_ledg: got %h expected %h", ld, eld);
    end
    idle_gap();
  endtask

  task automatic test_sw_toggle();
    logic [63:0] st, ld, est, eld;
    run_pattern(60, rng(1, 44), rng(1, 24) | rng(31, 60), st, ld);
    est = '0;
    est[7]  = 1'b1; est[17] = 1'b1; est[20] = 1'b1; est[23] = 1'b1;
    est[40] = 1'b1; est[43] = 1'b1; est[46] = 1'b1;
    eld = rng(7, 50);
    checks++;
    if (st !== est) begin
      errors++;
      $display("FAIL swtoggle_steps: got %h expected %h", st, est);
    end
    checks++;
    if (ld !== eld) begin
      errors++;
      $display("FAIL swtoggle_ledg: got %h expected %h", ld, eld);
    end
    idle_gap();
  endtask

  task automatic test_held_through_reset();
    logic [63:0] st, ld, est;
    bus.KEY[0] = 1'b0;
    bus.KEY[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.KEY[0] = 1'b1;
    run_pattern(12, rng(1, 12), '0, st, ld);
    est = '0;
    est[7] = 1'b1;
    checks++;
    if (st !== est) begin
      errors++;
      $display("FAIL heldreset_steps: got %h expected %h", st, est);
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_sw_toggle();
    test_reset_in_repeat();
    test_held_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
